serial_port: RTL and testbench

SERIAL_PORT -- requirements
Module: serial_port

---
 rtl/serial_port.sv | 229 ++++++++++++++++++++++
 tb/tb_serial_port.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port.sv
// 8051-style serial port: SCON/SBUF SFRs with mode 1/3 transmit and receive state machines.
// Define SERIAL_PORT_SMOD_EN to let smod double the sample rate; otherwise baud_tick is halved.
module serial_port #(
  parameter logic [7:0] SBUF_ADDR = 8'h99,
  parameter logic [7:0] SCON_ADDR = 8'h98
) (
  input  logic       xtal2,
  input  logic       rst,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_we,
  output logic [7:0] sfr_rdata,
  input  logic       baud_tick,
  input  logic       smod,
  input  logic       rxd,
  output logic       txd,
  output logic       serial_irq
);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxBit9, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxBit9, RxStop} rx_state_e;

  logic [7:0] scon_q, scon_d;
  logic       div_q, div_d;
  logic       samp_tick;

  tx_state_e  tx_state_q, tx_state_d;
  logic       tx_pend_q, tx_pend_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       txd_q, txd_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_bit9_q, rx_bit9_d;
  logic [7:0] rx_buf_q, rx_buf_d;

  logic mode_ok, mode3, ren, sm2;
  logic ti_set, ri_set, rb8_load, rb8_val;
  logic sbuf_we;

  assign mode_ok = scon_q[6];
  assign mode3   = scon_q[7] & scon_q[6];
  assign sm2     = scon_q[5];
  assign ren     = scon_q[4];
  assign sbuf_we = sfr_we && (sfr_addr == SBUF_ADDR);

  assign div_d = baud_tick ? ~div_q : div_q;
`ifdef SERIAL_PORT_SMOD_EN
  assign samp_tick = baud_tick & (smod | div_q);
`else
  logic smod_unused;
  assign smod_unused = smod;
  assign samp_tick   = baud_tick & div_q;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pend_d  = tx_pend_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    ti_set     = 1'b0;
    if (!mode_ok) begin
      tx_state_d = TxIdle;
      tx_pend_d  = 1'b0;
      tx_cnt_d   = 4'd0;
      tx_bit_d   = 3'd0;
      txd_d      = 1'b1;
    end else if (tx_state_q == TxIdle) begin
      // A write is latched first; the start bit aligns to the next sample tick.
      if (tx_pend_q) begin
        if (samp_tick) begin
          tx_state_d = TxStart;
          tx_pend_d  = 1'b0;
          tx_cnt_d   = 4'd0;
          txd_d      = 1'b0;
        end
      end else if (sbuf_we) begin
        tx_shift_d = sfr_wdata;
        tx_pend_d  = 1'b1;
      end
    end else if (samp_tick) begin
      tx_cnt_d = tx_cnt_q + 4'd1;
      if (tx_cnt_q == 4'd15) begin
        unique case (tx_state_q)
          TxStart: begin
            tx_state_d = TxData;
            tx_bit_d   = 3'd0;
            txd_d      = tx_shift_q[0];
          end
          TxData: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_d = mode3 ? TxBit9 : TxStop;
              txd_d      = mode3 ? scon_q[3] : 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              txd_d    = tx_shift_q[tx_bit_d];
            end
          end
          TxBit9: begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end
          TxStop: begin
            tx_state_d = TxIdle;
            ti_set     = 1'b1;
          end
          default: tx_state_d = TxIdle;
        endcase
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_bit9_d  = rx_bit9_q;
    rx_buf_d   = rx_buf_q;
    ri_set     = 1'b0;
    rb8_load   = 1'b0;
    rb8_val    = 1'b0;
    if (!mode_ok || !ren) begin
      rx_state_d = RxIdle;
      rx_cnt_d   = 4'd0;
    end else if (rx_state_q == RxIdle) begin
      if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RxStart;
        rx_cnt_d   = 4'd0;
        rx_bit_d   = 3'd0;
      end
    end else if (samp_tick) begin
      rx_cnt_d = rx_cnt_q + 4'd1;
      if (rx_cnt_q == 4'd8) begin
        unique case (rx_state_q)
          RxStart: if (rx_s2_q) rx_state_d = RxIdle;
          RxData:  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          RxBit9:  rx_bit9_d = rx_s2_q;
          RxStop: begin
            rx_state_d = RxIdle;
            if (!scon_q[0] && (!sm2 || (!mode3 && rx_s2_q) || (mode3 && rx_bit9_q))) begin
              rx_buf_d = rx_shift_q;
              rb8_load = 1'b1;
              rb8_val  = mode3 ? rx_bit9_q : rx_s2_q;
              ri_set   = 1'b1;
            end
          end
          default: rx_state_d = RxIdle;
        endcase
      end else if (rx_cnt_q == 4'd15) begin
        unique case (rx_state_q)
          RxStart: rx_state_d = RxData;
          RxData: begin
            if (rx_bit_q == 3'd7) rx_state_d = mode3 ? RxBit9 : RxStop;
            else rx_bit_d = rx_bit_q + 3'd1;
          end
          RxBit9:  rx_state_d = RxStop;
          default: rx_state_d = RxIdle;
        endcase
      end
    end
  end

  // Hardware flag updates are applied after the software write so they win.
  always_comb begin
    scon_d = scon_q;
    if (sfr_we && (sfr_addr == SCON_ADDR)) scon_d = sfr_wdata;
    if (rb8_load) scon_d[2] = rb8_val;
    if (ti_set) scon_d[1] = 1'b1;
    if (ri_set) scon_d[0] = 1'b1;
  end

  always_comb begin
    sfr_rdata = 8'h00;
    if (sfr_addr == SCON_ADDR) sfr_rdata = scon_q;
    else if (sfr_addr == SBUF_ADDR) sfr_rdata = rx_buf_q;
  end

  assign txd        = txd_q;
  assign serial_irq = scon_q[1] | scon_q[0];

  always_ff @(posedge xtal2) begin
    if (rst) begin
      scon_q     <= 8'h00;
      div_q      <= 1'b0;
      tx_state_q <= TxIdle;
      tx_pend_q  <= 1'b0;
      tx_shift_q <= 8'h00;
      tx_cnt_q   <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      rx_state_q <= RxIdle;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_bit9_q  <= 1'b0;
      rx_buf_q   <= 8'h00;
    end else begin
      scon_q     <= scon_d;
      div_q      <= div_d;
      tx_state_q <= tx_state_d;
      tx_pend_q  <= tx_pend_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_bit9_q  <= rx_bit9_d;
      rx_buf_q   <= rx_buf_d;
    end
  end

endmodule

// File: tb/tb_serial_port.sv
// Bench for serial_port: SFR vector table, directed frame sequences and randomized
// TX/RX frames checked against a bit-list / acceptance-rule reference model.
module tb_serial_port;

  logic       xtal2 = 1'b0;
  logic       rst;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic       sfr_we;
  logic [7:0] sfr_rdata;
  logic       baud_tick;
  logic       smod;
  logic       rxd;
  logic       txd;
  logic       serial_irq;

  int n_vec = 0;
  int n_err = 0;
  int div;
  int p;

  // Reference state for the receive side.
  logic [7:0] m_buf;
  logic       m_rb8;
  logic       m_ri;

  serial_port dut (
    .xtal2     (xtal2),
    .rst       (rst),
    .sfr_addr  (sfr_addr),
    .sfr_wdata (sfr_wdata),
    .sfr_we    (sfr_we),
    .sfr_rdata (sfr_rdata),
    .baud_tick (baud_tick),
    .smod      (smod),
    .rxd       (rxd),
    .txd       (txd),
    .serial_irq(serial_irq)
  );

  always #5 xtal2 = ~xtal2;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_irq;
    logic       exp_txd;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge xtal2);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    sfr_addr  = a;
    sfr_wdata = d;
    sfr_we    = 1'b1;
    step();
    sfr_we   = 1'b0;
    sfr_addr = 8'h98;
    #1;
  endtask

  task automatic tx_frame(input logic m3, input logic [7:0] data, input logic tb8,
                          input logic second, input logic [7:0] data2, input logic do_rst);
    logic [10:0] bits;
    int          nb;
    bit          seen;
    int          bad;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (m3) bits[9] = tb8;
    nb = m3 ? 11 : 10;
    sfr_write(8'h98, {m3, 1'b1, 1'b0, 1'b0, tb8, 3'b000});
    sfr_write(8'h99, data);
    seen = 1'b0;
    for (int t = 0; t < 4 * div + 4 && !seen; t++) begin
      if (txd == 1'b0) seen = 1'b1;
      else step();
    end
    check("tx_start_seen", seen, 1);
    if (!seen) return;
    for (int j = 0; j <= nb * p; j++) begin
      if (j % p == p / 2) check($sformatf("tx_bit%0d", j / p), txd, bits[j / p]);
      if (j == nb * p - 1) check("tx_ti_early", sfr_rdata[1], 0);
      if (j == nb * p) begin
        check("tx_ti", sfr_rdata[1], 1);
        check("tx_irq", serial_irq, 1);
        check("tx_idle_txd", txd, 1);
      end
      if (do_rst && j == 3 * p) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_scon", sfr_rdata, 8'h00);
        check("rst_irq", serial_irq, 0);
        bad = 0;
        repeat (12 * p) begin
          step();
          if (serial_irq !== 1'b0 || txd !== 1'b1) bad++;
        end
        check("rst_no_ti", bad, 0);
        return;
      end
      if (second && j == 3 * p) begin
        sfr_addr  = 8'h99;
        sfr_wdata = data2;
        sfr_we    = 1'b1;
        step();
        sfr_we   = 1'b0;
        sfr_addr = 8'h98;
        #1;
      end else if (j < nb * p) begin
        step();
      end
    end
  endtask

  task automatic rx_frame(input logic m3, input logic sm2, input logic [7:0] data,
                          input logic b9, input logic stop, input logic pre_ri);
    logic [10:0] bits;
    int          nb;
    bit          acc;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (m3) begin
      bits[9]  = b9;
      bits[10] = stop;
    end else begin
      bits[9] = stop;
    end
    nb = m3 ? 11 : 10;
    sfr_write(8'h98, {m3, 1'b1, sm2, 1'b1, 1'b0, 1'b0, 1'b0, pre_ri});
    m_rb8 = 1'b0;
    m_ri  = pre_ri;
    for (int b = 0; b < nb; b++) begin
      rxd = bits[b];
      repeat (p) step();
    end
    rxd = 1'b1;
    repeat (4) step();
    acc = !pre_ri && (!sm2 || (!m3 && stop) || (m3 && b9));
    if (acc) begin
      m_buf = data;
      m_rb8 = m3 ? b9 : stop;
      m_ri  = 1'b1;
    end
    check("rx_ri", sfr_rdata[0], m_ri);
    check("rx_rb8", sfr_rdata[2], m_rb8);
    sfr_addr = 8'h99;
    #1;
    check("rx_buf", sfr_rdata, m_buf);
    sfr_addr = 8'h98;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    sfr_addr  = 8'h98;
    sfr_wdata = 8'h00;
    sfr_we    = 1'b0;
    baud_tick = 1'b0;
    smod      = 1'b1;
    rxd       = 1'b1;
    m_buf     = 8'h00;
    m_rb8     = 1'b0;
    m_ri      = 1'b0;
`ifdef SERIAL_PORT_SMOD_EN
    div = smod ? 1 : 2;
`else
    div = 2;
`endif
    p = 16 * div;

    tbl[0]  = '{1'b0, 8'h98, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h99, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 8'h42, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'h98, 8'h03, 8'h03, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 8'h98, 8'h02, 8'h02, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 8'h98, 8'h01, 8'h01, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'h98, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 8'h99, 8'hFF, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h98, 8'hB0, 8'hB0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h98, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h42, 8'h77, 8'h00, 1'b0, 1'b1};

    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      sfr_addr  = tbl[i].addr;
      sfr_wdata = tbl[i].wdata;
      sfr_we    = tbl[i].we;
      step();
      sfr_we = 1'b0;
      #1;
      check($sformatf("vec%0d_rdata", i), sfr_rdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), serial_irq, tbl[i].exp_irq);
      check($sformatf("vec%0d_txd", i), txd, tbl[i].exp_txd);
    end
    sfr_addr  = 8'h98;
    baud_tick = 1'b1;

    // Directed frames.
    tx_frame(1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    tx_frame(1'b0, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0);
    tx_frame(1'b1, 8'h96, 1'b1, 1'b0, 8'h00, 1'b0);
    rx_frame(1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
    rx_frame(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    rx_frame(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);

    // Short low glitch must be rejected as a false start.
    sfr_write(8'h98, 8'h50);
    m_rb8 = 1'b0;
    rxd   = 1'b0;
    repeat (4 * div) step();
    rxd = 1'b1;
    repeat (p + 4) step();
    check("glitch_ri", sfr_rdata[0], 0);
    rx_frame(1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a transmission.
    tx_frame(1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1);
    m_buf = 8'h00;
    m_rb8 = 1'b0;
    sfr_addr = 8'h99;
    #1;
    check("rst_rxbuf", sfr_rdata, 8'h00);
    sfr_addr = 8'h98;
    #1;

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      tx_frame(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      rx_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
